adc_ram_reader: RTL and testbench

- Read-side counterpart of the ADC capture path: after the ADC writer fills the sample RAM, this block reads it back out.
- On a PS read request it reads words 0..N-1 from the RAM's second port and streams them over an AXI4-Stream master toward the PS DMA.
- Handles RAM read latency and stream backpressure with an internal skid FIFO.
- Aborts cleanly if a new capture starts overwriting the RAM mid-readout.

---
 rtl/adc_ram_reader.sv | 206 ++++++++++++++++++++
 tb/tb_adc_ram_reader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_ram_reader.sv
// adc_ram_reader: reads words 0..N-1 back from the capture RAM and streams them over AXI4-Stream.
// Optional build macro ADC_RD_HEADER_EN prepends one header beat carrying N before the data.
module adc_ram_reader #(
  parameter int DATA_WIDTH  = 16,
  parameter int AWIDTH      = 16,
  parameter int MEM_SIZE    = 10000,
  parameter int RAM_LATENCY = 2
) (
  input  logic                      i_clk,
  input  logic                      i_fRST,
  input  logic                      i_save_done,
  input  logic                      i_rd_start,
  input  logic [$clog2(MEM_SIZE):0] i_rd_size,
  output logic [AWIDTH-1:0]         o_ram_addr,
  output logic                      o_ram_ce,
  output logic                      o_ram_we,
  input  logic [DATA_WIDTH-1:0]     i_ram_dout,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_abort_err
);
  localparam int CW    = $clog2(MEM_SIZE) + 1;
  localparam int DEPTH = RAM_LATENCY + 2;
  localparam int PW    = $clog2(DEPTH);
  localparam int FCW   = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          n_q, n_d, issued_q, issued_d, cap_idx_q, cap_idx_d;
  logic                   ce_q, ce_d;
  logic [AWIDTH-1:0]      addr_q, addr_d;
  logic [RAM_LATENCY-1:0] pipe_q, pipe_d;
  logic [DATA_WIDTH-1:0]  fifo_data_q [DEPTH];
  logic [DATA_WIDTH-1:0]  fifo_data_d [DEPTH];
  logic [DEPTH-1:0]       fifo_last_q, fifo_last_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCW-1:0]         count_q, count_d;
  logic                   busy_q, busy_d, done_q, done_d;
  logic                   abort_err_q, abort_err_d, aborting_q, aborting_d;

  logic [CW-1:0] rd_n;
  logic          pop, push, abort_now, pending;
  int            outstanding;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rd_n = (i_rd_size > CW'(MEM_SIZE)) ? CW'(MEM_SIZE) : i_rd_size;

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    issued_d    = issued_q;
    cap_idx_d   = cap_idx_q;
    addr_d      = addr_q;
    fifo_data_d = fifo_data_q;
    fifo_last_d = fifo_last_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    busy_d      = busy_q;
    abort_err_d = abort_err_q;
    aborting_d  = aborting_q;
    done_d      = 1'b0;
    ce_d        = 1'b0;
    pipe_d[0]   = ce_q;
    for (int i = 1; i < RAM_LATENCY; i++) pipe_d[i] = pipe_q[i-1];

    pop       = (count_q != '0) && m_axis_tready;
    push      = pipe_q[RAM_LATENCY-1];
    abort_now = ((state_q == FETCH) || (state_q == DRAIN)) && !i_save_done && !aborting_q;
    pending   = ce_q || (pipe_q != '0) || (count_q != '0);
    // Everything already committed (queued, in the RAM pipe, or just issued) must fit the FIFO.
    outstanding = int'(count_q) + int'(ce_q) + $countones(pipe_q) - int'(pop);

    if (push) begin
      fifo_data_d[wr_ptr_q] = i_ram_dout;
      fifo_last_d[wr_ptr_q] = (cap_idx_q == n_q - 1'b1);
      wr_ptr_d              = ptr_inc(wr_ptr_q);
      cap_idx_d             = cap_idx_q + 1'b1;
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    count_d = count_q + FCW'(push) - FCW'(pop);

    case (state_q)
      IDLE: begin
        if (i_rd_start && i_save_done) begin
          n_d         = rd_n;
          issued_d    = '0;
          cap_idx_d   = '0;
          abort_err_d = 1'b0;
          aborting_d  = 1'b0;
          busy_d      = 1'b1;
          state_d     = FETCH;
`ifdef ADC_RD_HEADER_EN
          fifo_data_d[wr_ptr_q] = DATA_WIDTH'(rd_n);
          fifo_last_d[wr_ptr_q] = (rd_n == '0);
          wr_ptr_d              = ptr_inc(wr_ptr_q);
          count_d               = FCW'(1);
`endif
        end
      end
      FETCH: begin
        if (issued_q < n_q) begin
          if (outstanding < DEPTH) begin
            ce_d     = 1'b1;
            addr_d   = AWIDTH'(issued_q);
            issued_d = issued_q + 1'b1;
          end
        end else if (!pending) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!pending) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Overwrite in progress: keep only a beat already on the bus, drop everything behind it.
    if (abort_now) begin
      abort_err_d = 1'b1;
      aborting_d  = 1'b1;
      ce_d        = 1'b0;
      addr_d      = addr_q;
      issued_d    = issued_q;
      cap_idx_d   = cap_idx_q;
      pipe_d      = '0;
      done_d      = 1'b0;
      busy_d      = busy_q;
      state_d     = DRAIN;
      if ((count_q != '0) && !pop) begin
        count_d  = FCW'(1);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        count_d  = '0;
        rd_ptr_d = '0;
        wr_ptr_d = '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_fRST) begin
      state_q     <= IDLE;
      n_q         <= '0;
      issued_q    <= '0;
      cap_idx_q   <= '0;
      ce_q        <= 1'b0;
      addr_q      <= '0;
      pipe_q      <= '0;
      for (int i = 0; i < DEPTH; i++) fifo_data_q[i] <= '0;
      fifo_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      abort_err_q <= 1'b0;
      aborting_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      issued_q    <= issued_d;
      cap_idx_q   <= cap_idx_d;
      ce_q        <= ce_d;
      addr_q      <= addr_d;
      pipe_q      <= pipe_d;
      fifo_data_q <= fifo_data_d;
      fifo_last_q <= fifo_last_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      abort_err_q <= abort_err_d;
      aborting_q  <= aborting_d;
    end
  end

  assign o_ram_addr    = addr_q;
  assign o_ram_ce      = ce_q;
  assign o_ram_we      = 1'b0;
  assign m_axis_tvalid = (count_q != '0);
  assign m_axis_tdata  = fifo_data_q[rd_ptr_q];
  assign m_axis_tlast  = fifo_last_q[rd_ptr_q] && (count_q != '0) && !aborting_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_abort_err   = abort_err_q;

endmodule

// File: tb/tb_adc_ram_reader.sv
// Bench for adc_ram_reader: RAM model with read latency, expected-beat queue, per-cycle stream checker.
module tb_adc_ram_reader;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int MS = 10000;
  localparam int L  = 2;
  localparam int CW = $clog2(MS) + 1;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic          clk, rst, save_done, rd_start, tready;
  logic [CW-1:0] rd_size;
  logic [AW-1:0] ram_addr;
  logic          ram_ce, ram_we, tvalid, tlast, busy, done, abort_err;
  logic [DW-1:0] ram_dout, tdata;

  adc_ram_reader #(.DATA_WIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS), .RAM_LATENCY(L)) dut (
    .i_clk(clk), .i_fRST(rst), .i_save_done(save_done), .i_rd_start(rd_start),
    .i_rd_size(rd_size), .o_ram_addr(ram_addr), .o_ram_ce(ram_ce), .o_ram_we(ram_we),
    .i_ram_dout(ram_dout), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tlast(tlast), .o_busy(busy), .o_done(done),
    .o_abort_err(abort_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model: data for an address presented with CE appears on dout L cycles later.
  logic [DW-1:0] mem [0:65535];
  logic [DW-1:0] rd_pipe [L];
  initial for (int k = 0; k < 65536; k++) mem[k] = DW'(k + 16'h0100);
  always @(posedge clk) begin
    if (ram_ce) rd_pipe[0] <= mem[ram_addr];
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_dout = rd_pipe[L-1];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0, beats = 0, done_cnt = 0, tlast_seen = 0;
  bit bp_mode = 0;
  beat_t exp_q[$];
  logic [DW-1:0] got_d[$];
  logic          got_l[$];
  int            got_c[$];
  logic          prev_stall = 0;
  logic [DW-1:0] prev_d;
  logic          prev_l;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Stream checker: every handshake must match the next expected beat; stalled beats must hold.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("ram_we_zero", 32'(ram_we), 32'd0);
      if (prev_stall) begin
        chk("hold_valid", 32'(tvalid), 32'd1);
        chk("hold_data", 32'(tdata), 32'(prev_d));
        chk("hold_last", 32'(tlast), 32'(prev_l));
      end
      if (tvalid && tready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_beat: got data 0x%0h, expected no beat", tdata);
        end else begin
          if (tdata !== exp_q[0].d || tlast !== exp_q[0].l) begin
            n_fail++;
            $display("FAIL beat: got data 0x%0h last %0d, expected data 0x%0h last %0d",
                     tdata, tlast, exp_q[0].d, exp_q[0].l);
          end
          void'(exp_q.pop_front());
        end
        got_d.push_back(tdata);
        got_l.push_back(tlast);
        got_c.push_back(cyc);
        beats++;
        if (tlast) tlast_seen++;
      end
      if (done) done_cnt++;
      prev_stall = tvalid && !tready;
      prev_d     = tdata;
      prev_l     = tlast;
    end
  end

  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_mode) tready = ($urandom_range(0, 1) == 1);
    end
  end

  task automatic push_expected(input int n);
    int ne = (n > MS) ? MS : n;
`ifdef ADC_RD_HEADER_EN
    exp_q.push_back('{d: DW'(ne), l: (ne == 0)});
`endif
    for (int k = 0; k < ne; k++) exp_q.push_back('{d: mem[k], l: (k == ne - 1)});
  endtask

  task automatic pulse_start(input int n);
    @(posedge clk); #1;
    rd_size  = CW'(n);
    rd_start = 1'b1;
    @(posedge clk); #1;
    rd_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s_timeout: got no done pulse, required one within %0d cycles", nm, budget);
    end
  endtask

  task automatic run_read(input int n, input string nm);
    int d0 = done_cnt;
    got_d.delete(); got_l.delete(); got_c.delete();
    push_expected(n);
    pulse_start(n);
    wait_done(((n > MS) ? MS : n) * 8 + 60, nm);
    @(negedge clk);
    chk({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
    chk({nm, "_done_once"}, 32'(done_cnt - d0), 32'd1);
    chk({nm, "_busy_low"}, 32'(busy), 32'd0);
    chk({nm, "_valid_low"}, 32'(tvalid), 32'd0);
    exp_q.delete();
  endtask

  int off, b0, d0, t0, nb_drop;
  logic acc;

  initial begin
    rst = 1'b1; save_done = 1'b0; rd_start = 1'b0; rd_size = '0;
`ifdef ADC_RD_HEADER_EN
    off = 1;
`else
    off = 0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(tvalid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_abort", 32'(abort_err), 32'd0);
    chk("rst_ce", 32'(ram_ce), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    save_done = 1'b1;

    // Normal read, N=8, tready held high
    run_read(8, "normal");
    chk("normal_first", 32'(got_d[off]), 32'h0100);
    chk("normal_last", 32'(got_d[off + 7]), 32'h0107);
    chk("normal_tlast", 32'(got_l[off + 7]), 32'd1);
    chk("normal_gapless", 32'(got_c[off + 7] - got_c[off]), 32'd7);

    // Backpressure, N=16
    bp_mode = 1;
    run_read(16, "bp");
    chk("bp_count", 32'(got_d.size()), 32'(16 + off));
    bp_mode = 0;
    @(posedge clk); #1;
    tready = 1'b1;

    // Start ignored without a complete capture
    save_done = 1'b0;
    acc = 1'b0;
    pulse_start(8);
    repeat (10) begin
      @(negedge clk);
      acc = acc | busy | ram_ce | tvalid;
    end
    chk("guard_idle", 32'(acc), 32'd0);
    save_done = 1'b1;

`ifndef ADC_RD_HEADER_EN
    // N=0: no beats, done one cycle after FETCH entry
    d0 = done_cnt;
    b0 = beats;
    pulse_start(0);
    @(negedge clk);
    chk("n0_busy", 32'(busy), 32'd1);
    chk("n0_done_early", 32'(done), 32'd0);
    @(negedge clk);
    chk("n0_done", 32'(done), 32'd1);
    @(negedge clk);
    chk("n0_no_beats", 32'(beats - b0), 32'd0);
    chk("n0_done_once", 32'(done_cnt - d0), 32'd1);
`else
    run_read(0, "n0_hdr");
    chk("n0_hdr_data", 32'(got_d[0]), 32'd0);
    chk("n0_hdr_last", 32'(got_l[0]), 32'd1);
`endif

    // Abort mid-read, N=100
    push_expected(100);
    b0 = beats;
    d0 = done_cnt;
    t0 = tlast_seen;
    pulse_start(100);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (beats - b0 >= 21) break;
    end
    @(posedge clk); #1;
    tready = 1'b0;
    save_done = 1'b0;
    nb_drop = beats - b0;
    @(negedge clk);
    chk("abort_pending_valid", 32'(tvalid), 32'd1);
    repeat (3) @(posedge clk);
    #1 tready = 1'b1;
    wait_done(100, "abort");
    repeat (3) @(negedge clk);
    chk("abort_beats", 32'(beats - b0), 32'(nb_drop + 1));
    chk("abort_no_tlast", 32'(tlast_seen - t0), 32'd0);
    chk("abort_err_set", 32'(abort_err), 32'd1);
    chk("abort_done_once", 32'(done_cnt - d0), 32'd1);
    chk("abort_busy_low", 32'(busy), 32'd0);
    exp_q.delete();
    save_done = 1'b1;
    run_read(4, "post_abort");
    chk("abort_err_cleared", 32'(abort_err), 32'd0);

    // Reset during streaming, then a clean read
    push_expected(32);
    b0 = beats;
    pulse_start(32);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (beats - b0 >= 5) break;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mrst_valid", 32'(tvalid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_addr", 32'(ram_addr), 32'd0);
    chk("mrst_ce", 32'(ram_ce), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_read(4, "after_rst");
    chk("after_rst_word0", 32'(got_d[off]), 32'h0100);
    chk("after_rst_word3", 32'(got_d[off + 3]), 32'h0103);

    // Oversized request is clamped to the RAM depth
    run_read(MS + 5, "clamp");
    chk("clamp_count", 32'(got_d.size()), 32'(MS + off));
    chk("clamp_last_word", 32'(got_d[got_d.size() - 1]), 32'h280F);

`ifdef ADC_RD_HEADER_EN
    run_read(3, "hdr3");
    chk("hdr3_header", 32'(got_d[0]), 32'd3);
    chk("hdr3_word0", 32'(got_d[1]), 32'h0100);
    chk("hdr3_word2", 32'(got_d[3]), 32'h0102);
    chk("hdr3_lasts", {28'd0, got_l[0], got_l[1], got_l[2], got_l[3]}, 32'b0001);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
